id_r_queue: RTL and testbench
=============================

Name: id_r_queue

Overview:
Registered, parametrised R-type decode stage for the ID pipeline. Each accepted instruction word is decoded into a micro-op (op code, register fields, shift amount, flags) and stored in a DEPTH-entry FIFO. The FIFO presents micro-ops to the issue logic with a valid/ready handshake. Adds back-pressure, flush, per-entry PC tagging, occupancy reporting and an optional SPECIAL2 decode that can be disabled at build time.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, 2..16
PC_WIDTH, 32, width of PC tag carried with each entry
OP_WIDTH, 8, width of op code field; all `OP_* codes from defs.v must fit
EN_SPECIAL2, 1, 1 = decode opcode 6'h1c group; 0 = opcode 6'h1c decodes as `OP_INVAILD

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  drop all entries and the input of this cycle
in_valid  in  1  inst/in_pc valid
in_ready  out  1  queue can accept this cycle
inst  in  32  instruction word
in_pc  in  PC_WIDTH  PC of inst
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes head this cycle
op  out  OP_WIDTH  decoded op of head entry
reg_s  out  5  inst[25:21] of head entry
reg_t  out  5  inst[20:16] of head entry
reg_d  out  5  inst[15:11] of head entry
shift  out  5  inst[10:6] of head entry
flag_unsigned  out  1  head entry is an unsigned variant
flag_invalid  out  1  head entry decoded to `OP_INVAILD (reserved-instruction trap)
out_pc  out  PC_WIDTH  PC tag of head entry
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Decode is combinational on inst at the input; only decoded fields are stored, not inst.
- Opcode 6'h00 funct map: 00 SLL, 02 SRL, 03 SRA, 04 SLLV, 06 SRLV, 07 SRAV, 08 JR, 09 JALR, 0a MOVZ, 0b MOVN, 0c SYSCALL, 0d BREAK, 0f SYNC, 10 MFHI, 11 MTHI, 12 MFLO, 13 MTLO, 18/19 MULT, 1a/1b DIV, 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2a/2b SLT. Any other funct -> `OP_INVAILD.
- Opcode 6'h1c funct map, only when EN_SPECIAL2=1: 00/01 MADD, 02 MUL, 04/05 MSUB, 20 CLZ, 21 CLO. Any other funct -> `OP_INVAILD.
- Any other opcode -> `OP_INVAILD.
- flag_unsigned is set only for opcode 00 with funct 21/23/2b/19/1b, or opcode 1c (EN_SPECIAL2=1) with funct 01/05. It is 0 for every other encoding, including invalid ones.
- flag_invalid = (op == `OP_INVAILD).
- Push = in_valid && in_ready && !flush. Pop = out_valid && out_ready && !flush.
- in_ready = (count < DEPTH). It is independent of out_ready: a full queue does not accept even when popping in the same cycle.
- Latency: an entry pushed in cycle N is visible at the head (out_valid=1) in cycle N+1 at the earliest. There is no combinational in-to-out path.
- Push and pop in the same cycle: count unchanged, order preserved.
- Head fields are driven from the entry at the read pointer. When out_valid=0, head fields hold their last values; consumers must ignore them.
- Read/write pointers wrap modulo DEPTH.
- count holds 0..DEPTH. out_valid = (count != 0).
- flush: next cycle count=0, pointers=0, out_valid=0. Input offered in the flush cycle is dropped. flush has priority over push and pop.
- rst has priority over flush. Reset values: count=0, out_valid=0, in_ready=1 (from count), pointers=0, op=`OP_INVAILD, flag_invalid=1, flag_unsigned=0, reg_s/reg_t/reg_d/shift=0, out_pc=0.
- Reset asserted mid-stream discards all entries; no pop or push takes effect in that cycle.

Test Plan:
- Single push: inst=0x00851021 (addu $2,$4,$5), pc=0x100 -> next cycle out_valid=1, op=`OP_ADD, reg_s=4, reg_t=5, reg_d=2, flag_unsigned=1, flag_invalid=0, out_pc=0x100, count=1.
- Fill and back-pressure, DEPTH=4, out_ready=0: push 4 words (sll, srl, sra, jr) -> count=4, in_ready=0. Fifth word is not accepted. Then out_ready=1 -> ops pop in order SLL, SRL, SRA, JR; count falls 4,3,2,1,0.
- Steady streaming, out_ready=1, in_valid=1 every cycle -> one push and one pop per cycle after the first, count stays 1, with no bubbles or reordering across pointer wrap (>= 2*DEPTH words).
- Invalid and SPECIAL2: inst=0x70850821 (clo) -> op=`OP_CLO with EN_SPECIAL2=1; op=`OP_INVAILD, flag_invalid=1 with EN_SPECIAL2=0. inst=0x00000001 -> flag_invalid=1, flag_unsigned=0.
- Flush with count=3 while pushing inst=0x00000018 (mult) -> next cycle count=0, out_valid=0, mult not enqueued. Next push appears after 1 cycle.
- Reset mid-operation, count=2 and rst=1 for one cycle -> count=0, out_valid=0, op=`OP_INVAILD, flag_invalid=1, in_ready=1.

Source files
------------

// File: rtl/id_r_queue.sv
// ============================================================================
// Module   : id_r_queue
// Brief    : R-type decode stage feeding a DEPTH-entry micro-op FIFO with
//            valid/ready handshake, flush, PC tagging and occupancy output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_r_queue #(
    parameter int DEPTH       = 4,
    parameter int PC_WIDTH    = 32,
    parameter int OP_WIDTH    = 8,
    parameter int EN_SPECIAL2 = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                inst,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OP_WIDTH-1:0]        op,
    output logic [4:0]                 reg_s,
    output logic [4:0]                 reg_t,
    output logic [4:0]                 reg_d,
    output logic [4:0]                 shift,
    output logic                       flag_unsigned,
    output logic                       flag_invalid,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0]       c_ptr_one = PW'(1);
    localparam logic [CW-1:0]       c_cnt_one = CW'(1);
    localparam logic [CW-1:0]       c_depth   = CW'(DEPTH);

    // Micro-op encoding shared with the issue logic
    localparam logic [OP_WIDTH-1:0] c_op_invaild = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] c_op_sll     = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] c_op_srl     = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] c_op_sra     = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] c_op_sllv    = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] c_op_srlv    = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] c_op_srav    = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] c_op_jr      = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] c_op_jalr    = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] c_op_movz    = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] c_op_movn    = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] c_op_syscall = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] c_op_break   = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] c_op_sync    = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] c_op_mfhi    = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] c_op_mthi    = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] c_op_mflo    = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] c_op_mtlo    = OP_WIDTH'(17);
    localparam logic [OP_WIDTH-1:0] c_op_mult    = OP_WIDTH'(18);
    localparam logic [OP_WIDTH-1:0] c_op_div     = OP_WIDTH'(19);
    localparam logic [OP_WIDTH-1:0] c_op_add     = OP_WIDTH'(20);
    localparam logic [OP_WIDTH-1:0] c_op_sub     = OP_WIDTH'(21);
    localparam logic [OP_WIDTH-1:0] c_op_and     = OP_WIDTH'(22);
    localparam logic [OP_WIDTH-1:0] c_op_or      = OP_WIDTH'(23);
    localparam logic [OP_WIDTH-1:0] c_op_xor     = OP_WIDTH'(24);
    localparam logic [OP_WIDTH-1:0] c_op_nor     = OP_WIDTH'(25);
    localparam logic [OP_WIDTH-1:0] c_op_slt     = OP_WIDTH'(26);
    localparam logic [OP_WIDTH-1:0] c_op_madd    = OP_WIDTH'(27);
    localparam logic [OP_WIDTH-1:0] c_op_mul     = OP_WIDTH'(28);
    localparam logic [OP_WIDTH-1:0] c_op_msub    = OP_WIDTH'(29);
    localparam logic [OP_WIDTH-1:0] c_op_clz     = OP_WIDTH'(30);
    localparam logic [OP_WIDTH-1:0] c_op_clo     = OP_WIDTH'(31);

    typedef struct packed {
        logic [OP_WIDTH-1:0] op;
        logic                uns;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          rd;
        logic [4:0]          sa;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    entry_t              r_mem [DEPTH];
    entry_t              r_head;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic [OP_WIDTH-1:0] w_op;
    logic                w_uns;
    entry_t              w_dec;
    entry_t              w_head_nxt;
    logic [PW-1:0]       w_rd_nxt;
    logic [CW-1:0]       w_count_nxt;
    logic                w_push;
    logic                w_pop;

    // ---------------------------------------------------------------- decode
    always_comb begin
        w_op  = c_op_invaild;
        w_uns = 1'b0;
        case (inst[31:26])
            6'h00: begin
                case (inst[5:0])
                    6'h00: w_op = c_op_sll;
                    6'h02: w_op = c_op_srl;
                    6'h03: w_op = c_op_sra;
                    6'h04: w_op = c_op_sllv;
                    6'h06: w_op = c_op_srlv;
                    6'h07: w_op = c_op_srav;
                    6'h08: w_op = c_op_jr;
                    6'h09: w_op = c_op_jalr;
                    6'h0a: w_op = c_op_movz;
                    6'h0b: w_op = c_op_movn;
                    6'h0c: w_op = c_op_syscall;
                    6'h0d: w_op = c_op_break;
                    6'h0f: w_op = c_op_sync;
                    6'h10: w_op = c_op_mfhi;
                    6'h11: w_op = c_op_mthi;
                    6'h12: w_op = c_op_mflo;
                    6'h13: w_op = c_op_mtlo;
                    6'h18: w_op = c_op_mult;
                    6'h19: begin w_op = c_op_mult; w_uns = 1'b1; end
                    6'h1a: w_op = c_op_div;
                    6'h1b: begin w_op = c_op_div;  w_uns = 1'b1; end
                    6'h20: w_op = c_op_add;
                    6'h21: begin w_op = c_op_add;  w_uns = 1'b1; end
                    6'h22: w_op = c_op_sub;
                    6'h23: begin w_op = c_op_sub;  w_uns = 1'b1; end
                    6'h24: w_op = c_op_and;
                    6'h25: w_op = c_op_or;
                    6'h26: w_op = c_op_xor;
                    6'h27: w_op = c_op_nor;
                    6'h2a: w_op = c_op_slt;
                    6'h2b: begin w_op = c_op_slt;  w_uns = 1'b1; end
                    default: ;
                endcase
            end
            6'h1c: begin
                if (EN_SPECIAL2 != 0) begin
                    case (inst[5:0])
                        6'h00: w_op = c_op_madd;
                        6'h01: begin w_op = c_op_madd; w_uns = 1'b1; end
                        6'h02: w_op = c_op_mul;
                        6'h04: w_op = c_op_msub;
                        6'h05: begin w_op = c_op_msub; w_uns = 1'b1; end
                        6'h20: w_op = c_op_clz;
                        6'h21: w_op = c_op_clo;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_dec.op  = w_op;
        w_dec.uns = w_uns;
        w_dec.rs  = inst[25:21];
        w_dec.rt  = inst[20:16];
        w_dec.rd  = inst[15:11];
        w_dec.sa  = inst[10:6];
        w_dec.pc  = in_pc;
    end

    // ------------------------------------------------------------- handshake
    assign in_ready  = (r_count < c_depth);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    // The head is a register loaded with whatever will sit at the read pointer
    // next cycle; a push into the slot becoming head is forwarded from decode.
    always_comb begin
        w_rd_nxt    = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;
        w_head_nxt  = (w_push && (w_rd_nxt == r_wr_ptr)) ? w_dec : r_mem[w_rd_nxt];
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_head      <= '0;
            r_head.op   <= c_op_invaild;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            // Head fields hold their last values once the queue drains
            if ((w_push || w_pop) && (w_count_nxt != '0)) begin
                r_head <= w_head_nxt;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign op            = r_head.op;
    assign reg_s         = r_head.rs;
    assign reg_t         = r_head.rt;
    assign reg_d         = r_head.rd;
    assign shift         = r_head.sa;
    assign flag_unsigned = r_head.uns;
    assign flag_invalid  = (r_head.op == c_op_invaild);
    assign out_pc        = r_head.pc;
    assign count         = r_count;

endmodule

`default_nettype wire

// File: tb/tb_id_r_queue.sv
// ============================================================================
// Module   : tb_id_r_queue
// Brief    : Directed self-checking bench for id_r_queue (SPECIAL2 on and off).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_r_queue;

    localparam logic [7:0] OP_INVAILD = 8'd0;
    localparam logic [7:0] OP_SLL     = 8'd1;
    localparam logic [7:0] OP_SRL     = 8'd2;
    localparam logic [7:0] OP_SRA     = 8'd3;
    localparam logic [7:0] OP_JR      = 8'd7;
    localparam logic [7:0] OP_ADD     = 8'd20;
    localparam logic [7:0] OP_SUB     = 8'd21;
    localparam logic [7:0] OP_MADD    = 8'd27;
    localparam logic [7:0] OP_CLO     = 8'd31;

    localparam logic [31:0] W_ADDU = 32'h00851021;
    localparam logic [31:0] W_ADD  = 32'h00851020;
    localparam logic [31:0] W_SUBU = 32'h00851023;
    localparam logic [31:0] W_XOR  = 32'h00851026;
    localparam logic [31:0] W_CLO  = 32'h70850821;
    localparam logic [31:0] W_MADU = 32'h70000001;
    localparam logic [31:0] W_BAD  = 32'h00000001;
    localparam logic [31:0] W_MULT = 32'h00000018;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [31:0] in_pc;

    logic        in_ready_a, out_valid_a, uns_a, inv_a;
    logic [7:0]  op_a;
    logic [4:0]  rs_a, rt_a, rd_a, sa_a;
    logic [31:0] pc_a;
    logic [2:0]  count_a;

    logic        in_ready_b, out_valid_b, uns_b, inv_b;
    logic [7:0]  op_b;
    logic [4:0]  rs_b, rt_b, rd_b, sa_b;
    logic [31:0] pc_b;
    logic [2:0]  count_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] fill_words [4] = '{32'h000208C0, 32'h000208C2, 32'h000208C3, 32'h03E00008};
    logic [7:0]  fill_ops   [4] = '{OP_SLL, OP_SRL, OP_SRA, OP_JR};

    always #5 clk = ~clk;

    id_r_queue #(.DEPTH(4), .PC_WIDTH(32), .OP_WIDTH(8), .EN_SPECIAL2(1)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .inst(inst), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
        .op(op_a), .reg_s(rs_a), .reg_t(rt_a), .reg_d(rd_a), .shift(sa_a),
        .flag_unsigned(uns_a), .flag_invalid(inv_a), .out_pc(pc_a), .count(count_a)
    );

    id_r_queue #(.DEPTH(4), .PC_WIDTH(32), .OP_WIDTH(8), .EN_SPECIAL2(0)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .inst(inst), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
        .op(op_b), .reg_s(rs_b), .reg_t(rt_b), .reg_d(rd_b), .shift(sa_b),
        .flag_unsigned(uns_b), .flag_invalid(inv_b), .out_pc(pc_b), .count(count_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1;
        inst     = w;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; in_pc = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_count",    64'(count_a),     64'd0);
        check("rst_valid",    64'(out_valid_a), 64'd0);
        check("rst_in_ready", 64'(in_ready_a),  64'd1);
        check("rst_op",       64'(op_a),        64'(OP_INVAILD));
        check("rst_inv",      64'(inv_a),       64'd1);
        check("rst_uns",      64'(uns_a),       64'd0);
        check("rst_regs",     64'({rs_a, rt_a, rd_a, sa_a}), 64'd0);
        check("rst_pc",       64'(pc_a),        64'd0);

        // Single push: addu $2,$4,$5
        push_one(W_ADDU, 32'h100);
        check("single_valid", 64'(out_valid_a), 64'd1);
        check("single_op",    64'(op_a),        64'(OP_ADD));
        check("single_rs",    64'(rs_a),        64'd4);
        check("single_rt",    64'(rt_a),        64'd5);
        check("single_rd",    64'(rd_a),        64'd2);
        check("single_uns",   64'(uns_a),       64'd1);
        check("single_inv",   64'(inv_a),       64'd0);
        check("single_pc",    64'(pc_a),        64'h100);
        check("single_count", 64'(count_a),     64'd1);
        pop_one();
        check("single_drain", 64'(count_a),     64'd0);
        check("single_empty", 64'(out_valid_a), 64'd0);

        // Fill to DEPTH with consumer stalled
        for (int i = 0; i < 4; i++) begin
            check("fill_in_ready", 64'(in_ready_a), 64'd1);
            push_one(fill_words[i], 32'h10 + 32'(4 * i));
        end
        check("full_count",    64'(count_a),    64'd4);
        check("full_in_ready", 64'(in_ready_a), 64'd0);
        push_one(W_ADD, 32'h99);
        check("full_reject",   64'(count_a),    64'd4);
        check("full_head_op",  64'(op_a),       64'(OP_SLL));
        check("full_head_sa",  64'(sa_a),       64'd3);

        // Drain in order; first pop cycle also offers a word that must be refused
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inst      = W_ADD;
        for (int i = 0; i < 4; i++) begin
            check("drain_op",    64'(op_a),    64'(fill_ops[i]));
            check("drain_count", 64'(count_a), 64'(4 - i));
            tick();
            in_valid = 1'b0;
        end
        out_ready = 1'b0;
        check("drain_empty_count", 64'(count_a),     64'd0);
        check("drain_empty_valid", 64'(out_valid_a), 64'd0);

        // Streaming across pointer wrap
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inst  = 32'h00000020 | (32'(i) << 11);
            in_pc = 32'h200 + 32'(4 * i);
            tick();
            check("stream_pc",    64'(pc_a),        64'(32'h200 + 32'(4 * i)));
            check("stream_rd",    64'(rd_a),        64'(i));
            check("stream_count", 64'(count_a),     64'd1);
            check("stream_valid", 64'(out_valid_a), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("stream_end_count", 64'(count_a), 64'd0);

        // SPECIAL2 on (dut a) versus off (dut b), and reserved funct
        push_one(W_CLO, 32'h400);
        check("clo_op_a",  64'(op_a),  64'(OP_CLO));
        check("clo_inv_a", 64'(inv_a), 64'd0);
        check("clo_uns_a", 64'(uns_a), 64'd0);
        check("clo_op_b",  64'(op_b),  64'(OP_INVAILD));
        check("clo_inv_b", 64'(inv_b), 64'd1);
        pop_one();
        push_one(W_MADU, 32'h404);
        check("maddu_op_a",  64'(op_a),  64'(OP_MADD));
        check("maddu_uns_a", 64'(uns_a), 64'd1);
        check("maddu_uns_b", 64'(uns_b), 64'd0);
        check("maddu_inv_b", 64'(inv_b), 64'd1);
        pop_one();
        push_one(W_BAD, 32'h408);
        check("bad_inv", 64'(inv_a), 64'd1);
        check("bad_uns", 64'(uns_a), 64'd0);
        check("bad_op",  64'(op_a),  64'(OP_INVAILD));
        pop_one();

        // Flush with three entries while offering mult and popping
        for (int i = 0; i < 3; i++) begin
            push_one(fill_words[i], 32'h500 + 32'(4 * i));
        end
        check("preflush_count", 64'(count_a), 64'd3);
        flush = 1'b1; in_valid = 1'b1; inst = W_MULT; in_pc = 32'h600; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_count",    64'(count_a),     64'd0);
        check("flush_valid",    64'(out_valid_a), 64'd0);
        check("flush_in_ready", 64'(in_ready_a),  64'd1);
        push_one(W_SUBU, 32'h300);
        check("postflush_valid", 64'(out_valid_a), 64'd1);
        check("postflush_op",    64'(op_a),        64'(OP_SUB));
        check("postflush_uns",   64'(uns_a),       64'd1);
        check("postflush_pc",    64'(pc_a),        64'h300);
        check("postflush_count", 64'(count_a),     64'd1);
        push_one(W_XOR, 32'h304);
        check("prerst_count",   64'(count_a), 64'd2);
        check("prerst_head_op", 64'(op_a),    64'(OP_SUB));

        // Reset mid-stream with push and pop both offered
        rst = 1'b1; in_valid = 1'b1; inst = W_ADD; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("midrst_count",    64'(count_a),     64'd0);
        check("midrst_valid",    64'(out_valid_a), 64'd0);
        check("midrst_op",       64'(op_a),        64'(OP_INVAILD));
        check("midrst_inv",      64'(inv_a),       64'd1);
        check("midrst_in_ready", 64'(in_ready_a),  64'd1);
        check("midrst_pc",       64'(pc_a),        64'd0);
        tick();
        check("midrst_hold", 64'(count_a), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
